// File: rtl/clkgen_pkg.sv
// Shared encodings for the clock-generation sequencer.
// Selection codes, FSM states and divider width.
package clkgen_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [1:0] {
    SEL_F   = 2'd0,
    SEL_2F  = 2'd1,
    SEL_4F  = 2'd2,
    SEL_OFF = 2'd3
  } sel_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  function automatic logic sel_bit(
    input logic [1:0]         sel,
    input logic [PHASE_W-1:0] ph
  );
    logic b;
    b = 1'b0;
    unique case (sel)
      SEL_F:   b = ph[3];
      SEL_2F:  b = ph[2];
      SEL_4F:  b = ph[1];
      SEL_OFF: b = 1'b0;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/clkgen_sched_if.sv
// Selection request handshake between a requester and clkgen_sched.
// master drives requests, slave accepts and acknowledges them.
interface clkgen_sched_if;
  logic       sel_valid;
  logic [1:0] sel_code;
  logic       sel_ready;
  logic       sel_ack;

  modport master (
    output sel_valid,
    output sel_code,
    input  sel_ready,
    input  sel_ack
  );

  modport slave (
    input  sel_valid,
    input  sel_code,
    output sel_ready,
    output sel_ack
  );
endinterface

// File: rtl/clkgen_div.sv
// Free-running 4-bit divider on clk16f.
// Divided clocks are counter bits, so duty is exactly 50%.
module clkgen_div
  import clkgen_pkg::*;
(
  input  logic               clk16f,
  input  logic               reset,
  output logic [PHASE_W-1:0] phase,
  output logic               clk4f,
  output logic               clk2f,
  output logic               clkf,
  output logic               wrap
);

  always_ff @(posedge clk16f or posedge reset) begin
    if (reset) phase <= '0;
    else       phase <= phase + PHASE_W'(1);
  end

  assign clk4f = phase[1];
  assign clk2f = phase[2];
  assign clkf  = phase[3];
  assign wrap  = &phase;

endmodule

// File: rtl/clkgen_sched.sv
// Glitch-free divided-clock selector; switches land on the divider wrap.
// CLKGEN_STATUS_EN adds switch_cnt and req_drop status outputs.
module clkgen_sched
  import clkgen_pkg::*;
#(
  parameter logic [1:0] RESET_SEL = 2'd2
) (
  input  logic               clk16f,
  input  logic               reset,
  clkgen_sched_if.slave      req,
  output logic               clk4f,
  output logic               clk2f,
  output logic               clkf,
  output logic               clk_out,
  output logic [1:0]         cur_sel,
  output logic [PHASE_W-1:0] phase
`ifdef CLKGEN_STATUS_EN
  ,
  output logic [7:0]         switch_cnt,
  output logic               req_drop
`endif
);

  state_e             state;
  logic [1:0]         pend;
  logic               wrap;
  logic               ack_q;
  logic               ready_q;
  logic [PHASE_W-1:0] ph_nxt;

  clkgen_div u_div (
    .clk16f (clk16f),
    .reset  (reset),
    .phase  (phase),
    .clk4f  (clk4f),
    .clk2f  (clk2f),
    .clkf   (clkf),
    .wrap   (wrap)
  );

  assign ph_nxt        = phase + PHASE_W'(1);
  assign req.sel_ready = ready_q;
  assign req.sel_ack   = ack_q;

  // ph_nxt is 0 at the wrap, so the new selection always starts low
  always_ff @(posedge clk16f or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pend    <= '0;
      cur_sel <= RESET_SEL;
      ack_q   <= 1'b0;
      ready_q <= 1'b1;
      clk_out <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      clk_out <= sel_bit(cur_sel, ph_nxt);
      unique case (state)
        IDLE: begin
          if (req.sel_valid) begin
            pend    <= req.sel_code;
            state   <= PENDING;
            ready_q <= 1'b0;
          end
        end
        PENDING: begin
          if (wrap) begin
            cur_sel <= pend;
            state   <= IDLE;
            ready_q <= 1'b1;
            ack_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLKGEN_STATUS_EN
  always_ff @(posedge clk16f or posedge reset) begin
    if (reset) begin
      switch_cnt <= '0;
      req_drop   <= 1'b0;
    end else begin
      req_drop <= req.sel_valid && (state == PENDING);
      if (state == PENDING && wrap && switch_cnt != 8'hff)
        switch_cnt <= switch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clkgen_sched.sv
// Scoreboard bench for clkgen_sched: driver queues expected acks,
// negedge monitor checks divider, clk_out, handshake and acks.
module tb_clkgen_sched;
  import clkgen_pkg::*;

  logic       clk16f = 1'b0;
  logic       reset  = 1'b0;
  logic       clk4f, clk2f, clkf, clk_out;
  logic [1:0] cur_sel;
  logic [3:0] phase;
`ifdef CLKGEN_STATUS_EN
  logic [7:0] switch_cnt;
  logic       req_drop;
  int         n_ack  = 0;
  int         n_drop = 0;
`endif

  clkgen_sched_if bus ();

  clkgen_sched #(.RESET_SEL(2'd2)) dut (
    .clk16f     (clk16f),
    .reset      (reset),
    .req        (bus),
    .clk4f      (clk4f),
    .clk2f      (clk2f),
    .clkf       (clkf),
    .clk_out    (clk_out),
    .cur_sel    (cur_sel),
    .phase      (phase)
`ifdef CLKGEN_STATUS_EN
    ,
    .switch_cnt (switch_cnt),
    .req_drop   (req_drop)
`endif
  );

  always #5 clk16f = ~clk16f;

  typedef struct {
    int         acc;
    int         ack;
    logic [1:0] code;
  } exp_t;

  exp_t       sb[$];
  int         checks  = 0;
  int         errors  = 0;
  int         tcyc    = 0;
  logic [1:0] exp_sel = 2'd2;
  bit         run     = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at cyc %0d", nm, act, exp, tcyc);
    end
  endtask

  always @(posedge clk16f or posedge reset) begin
    if (reset) tcyc <= 0;
    else       tcyc <= tcyc + 1;
  end

  // monitor
  always @(negedge clk16f) begin
    if (!reset && run) begin
      logic [3:0] ph;
      logic       exp_clk;
      int         exp_rdy;
      exp_t       e;
      ph      = tcyc[3:0];
      exp_rdy = (sb.size() == 0 || tcyc <= sb[0].acc ||
                 tcyc >= sb[0].ack) ? 1 : 0;
      chk("sel_ready", int'(bus.sel_ready), exp_rdy);
      if (bus.sel_ack) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_cycle", tcyc, e.ack);
          chk("ack_sel", int'(cur_sel), int'(e.code));
          exp_sel = e.code;
`ifdef CLKGEN_STATUS_EN
          n_ack++;
          chk("switch_cnt", int'(switch_cnt), n_ack);
`endif
        end
      end else if (sb.size() != 0 && tcyc > sb[0].ack) begin
        chk("ack_missing", 0, 1);
        e = sb.pop_front();
      end
      case (exp_sel)
        2'd0:    exp_clk = ph[3];
        2'd1:    exp_clk = ph[2];
        2'd2:    exp_clk = ph[1];
        default: exp_clk = 1'b0;
      endcase
      chk("phase", int'(phase), int'(ph));
      chk("clk4f", int'(clk4f), int'(ph[1]));
      chk("clk2f", int'(clk2f), int'(ph[2]));
      chk("clkf", int'(clkf), int'(ph[3]));
      chk("cur_sel", int'(cur_sel), int'(exp_sel));
      chk("clk_out", int'(clk_out), int'(exp_clk));
`ifdef CLKGEN_STATUS_EN
      if (req_drop) n_drop++;
`endif
    end
  end

  task automatic goto_phase(input int p);
    int guard = 0;
    while (tcyc % 16 != p && guard < 20) begin
      @(negedge clk16f);
      guard++;
    end
  endtask

  task automatic req(input logic [1:0] code, input int lat);
    exp_t e;
    chk("ready_idle", int'(bus.sel_ready), 1);
    bus.sel_valid = 1'b1;
    bus.sel_code  = code;
    e.acc  = tcyc;
    e.ack  = tcyc + lat;
    e.code = code;
    sb.push_back(e);
    @(negedge clk16f);
    bus.sel_valid = 1'b0;
  endtask

  task automatic wait_ack();
    int guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(negedge clk16f);
      guard++;
    end
    if (sb.size() != 0) begin
      chk("wait_ack_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    bus.sel_valid = 1'b0;
    bus.sel_code  = 2'd0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk16f);
    chk("rst_phase", int'(phase), 0);
    chk("rst_cur_sel", int'(cur_sel), 2);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_ready", int'(bus.sel_ready), 1);
    chk("rst_ack", int'(bus.sel_ack), 0);
    reset = 1'b0;
    run   = 1'b1;
    repeat (32) @(negedge clk16f);

    // clk4f -> clkf, accepted at phase 5
    goto_phase(5);
    req(2'd0, 11);
    wait_ack();

    // accepted at phase 15: skips the immediate wrap
    goto_phase(15);
    req(2'd1, 17);
    wait_ack();

    // second request while pending is dropped
    goto_phase(2);
    req(2'd0, 14);
    chk("ready_busy", int'(bus.sel_ready), 0);
    bus.sel_valid = 1'b1;
    bus.sel_code  = 2'd3;
    @(negedge clk16f);
    bus.sel_valid = 1'b0;
    wait_ack();

    // OFF for a full period, then clk4f
    goto_phase(4);
    req(2'd3, 12);
    wait_ack();
    goto_phase(1);
    req(2'd2, 15);
    wait_ack();

    // reset at phase 9 while pending
    goto_phase(3);
    req(2'd1, 13);
    goto_phase(9);
    #1 reset = 1'b1;
    sb.delete();
    exp_sel = 2'd2;
`ifdef CLKGEN_STATUS_EN
    n_ack = 0;
`endif
    #1;
    chk("arst_phase", int'(phase), 0);
    chk("arst_clk4f", int'(clk4f), 0);
    chk("arst_clkf", int'(clkf), 0);
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_cur_sel", int'(cur_sel), 2);
    chk("arst_ack", int'(bus.sel_ack), 0);
    chk("arst_ready", int'(bus.sel_ready), 1);
`ifdef CLKGEN_STATUS_EN
    chk("arst_switch_cnt", int'(switch_cnt), 0);
`endif
    repeat (2) @(negedge clk16f);
    reset = 1'b0;
    repeat (40) @(negedge clk16f);
`ifdef CLKGEN_STATUS_EN
    chk("req_drop_count", n_drop, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
